// File: rtl/parallel_power2round_32bit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : parallel_power2round_32bit_pkg
//  Purpose  : Shared Dilithium constants and FSM state encoding for the
//             power2round stage of the key-generation datapath.
//  Revision : 1.0 - initial release
// ============================================================================
package parallel_power2round_32bit_pkg;

    localparam int Q       = 8380417;
    localparam int D       = 13;
    localparam int COEFF_W = 32;
    localparam int N_COEFF = 256;
    localparam int POLY_W  = N_COEFF * COEFF_W;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_PRE_RD_INP = 4'd1,
        ST_RD_INP     = 4'd2,
        ST_CALC       = 4'd3,
        ST_WR_OUT     = 4'd4,
        ST_DONE       = 4'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/power2round_lane.sv
`default_nettype none
// ============================================================================
//  Module   : power2round_lane
//  Purpose  : Combinational reduce32 + caddq + power2round for one signed
//             32-bit coefficient. a1 is the high part, a0 the signed low part.
//  Revision : 1.0 - initial release
// ============================================================================
module power2round_lane
    import parallel_power2round_32bit_pkg::*;
(
    input  logic [COEFF_W-1:0] a,
    output logic [COEFF_W-1:0] a1,
    output logic [COEFF_W-1:0] a0
);

    localparam logic signed [COEFF_W-1:0] Q_S       = 32'(Q);
    localparam logic signed [COEFF_W-1:0] HALF_BIAS = 32'sd4194304;     // 2^22
    localparam logic signed [COEFF_W-1:0] RND_D     = 32'((1 << (D - 1)) - 1);

    logic signed [COEFF_W-1:0] a_s;
    logic signed [COEFF_W-1:0] t;
    logic signed [COEFF_W-1:0] r_red;
    logic signed [COEFF_W-1:0] r_pos;
    logic signed [COEFF_W-1:0] hi;
    logic signed [COEFF_W-1:0] lo;

    assign a_s = $signed(a);

    // reduce32 brings a into (-Q, Q); caddq lifts negatives; then split at 2^D
    always_comb begin
        t     = (a_s + HALF_BIAS) >>> 23;
        r_red = a_s - t * Q_S;
        r_pos = r_red + ((r_red >>> (COEFF_W - 1)) & Q_S);
        hi    = (r_pos + RND_D) >>> D;
        lo    = r_pos - (hi <<< D);
    end

    assign a1 = hi;
    assign a0 = lo;

endmodule
`default_nettype wire

// File: rtl/parallel_power2round_32bit.sv
`default_nettype none
// ============================================================================
//  Module   : parallel_power2round_32bit
//  Purpose  : Applies reduce32, caddq and power2round (D=13) to all 256
//             coefficients of a polynomial, LANES coefficients per cycle,
//             with the start/rd_ready/rd_done/done/wr_done handshake.
//  Options  : ADD_S2_EN - adds port s2; each coefficient becomes inp+s2.
//  Revision : 1.0 - initial release
// ============================================================================
module parallel_power2round_32bit
    import parallel_power2round_32bit_pkg::*;
#(
    parameter int LANES = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic signed [0:POLY_W-1]   inp,
`ifdef ADD_S2_EN
    input  logic signed [0:POLY_W-1]   s2,
`endif
    output logic                       rd_ready,
    output logic                       rd_done,
    output logic                       done,
    output logic                       wr_done,
    output logic signed [0:POLY_W-1]   out_a1,
    output logic signed [0:POLY_W-1]   out_a0
);

    localparam int NCH = N_COEFF / LANES;

    state_t state;
    state_t state_nxt;

    logic [8:0]         chunk;
    logic [8:0]         sel;
    logic [12:0]        base;
    logic [0:POLY_W-1]  inp_reg;
`ifdef ADD_S2_EN
    logic [0:POLY_W-1]  s2_reg;
`endif
    logic [0:POLY_W-1]  a1_buf;
    logic [0:POLY_W-1]  a0_buf;

    logic [COEFF_W-1:0] lane_in [LANES];
    logic [COEFF_W-1:0] lane_a1 [LANES];
    logic [COEFF_W-1:0] lane_a0 [LANES];

    // The counter runs one past the last chunk before IDLE clears it; fold
    // that value back to 0 so the lane muxes never index outside the buffer.
    assign sel  = (chunk < 9'(NCH)) ? chunk : 9'd0;
    // With LANES=256 the chunk stride truncates to 0, which is fine because
    // sel is then always 0.
    assign base = 13'(sel) * 13'(LANES * COEFF_W);

    genvar j;
    generate
        for (j = 0; j < LANES; j++) begin : g_lane
`ifdef ADD_S2_EN
            assign lane_in[j] = inp_reg[base + 13'(j * COEFF_W) +: COEFF_W]
                              + s2_reg[base + 13'(j * COEFF_W) +: COEFF_W];
`else
            assign lane_in[j] = inp_reg[base + 13'(j * COEFF_W) +: COEFF_W];
`endif
            power2round_lane u_lane (
                .a  (lane_in[j]),
                .a1 (lane_a1[j]),
                .a0 (lane_a0[j])
            );
        end
    endgenerate

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:       state_nxt = ST_PRE_RD_INP;
            ST_PRE_RD_INP: if (start) state_nxt = ST_RD_INP;
            ST_RD_INP:     state_nxt = ST_CALC;
            ST_CALC:       if (chunk == 9'(NCH - 1)) state_nxt = ST_WR_OUT;
            ST_WR_OUT:     state_nxt = ST_DONE;
            ST_DONE:       state_nxt = ST_IDLE;
            default:       state_nxt = ST_IDLE;
        endcase
    end

    // Handshake flags, capture registers, chunk counter and result buffers
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ready <= 1'b0;
            rd_done  <= 1'b0;
            done     <= 1'b0;
            wr_done  <= 1'b0;
            chunk    <= 9'd0;
            inp_reg  <= '0;
`ifdef ADD_S2_EN
            s2_reg   <= '0;
`endif
            a1_buf   <= '0;
            a0_buf   <= '0;
            out_a1   <= '0;
            out_a0   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    rd_ready <= 1'b0;
                    rd_done  <= 1'b0;
                    done     <= 1'b0;
                    wr_done  <= 1'b0;
                    chunk    <= 9'd0;
                end
                ST_PRE_RD_INP: begin
                    if (start) begin
                        rd_ready <= 1'b1;
                    end
                end
                ST_RD_INP: begin
                    inp_reg  <= inp;
`ifdef ADD_S2_EN
                    s2_reg   <= s2;
`endif
                    rd_ready <= 1'b0;
                    rd_done  <= 1'b1;
                    chunk    <= 9'd0;
                end
                ST_CALC: begin
                    for (int k = 0; k < LANES; k++) begin
                        a1_buf[base + 13'(k * COEFF_W) +: COEFF_W] <= lane_a1[k];
                        a0_buf[base + 13'(k * COEFF_W) +: COEFF_W] <= lane_a0[k];
                    end
                    chunk <= chunk + 9'd1;
                end
                ST_WR_OUT: begin
                    out_a1  <= a1_buf;
                    out_a0  <= a0_buf;
                    done    <= 1'b1;
                    wr_done <= 1'b1;
                end
                ST_DONE: begin
                    done <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
